// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one WIDTH-bit adder among N_REQ requesters.
// One transaction in flight: accept (IDLE) -> add (CALC) -> hold result until taken (RESP).
module adder_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH:0]           rsp_sum,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [7:0]               op_count,
    output logic                     busy
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic [ID_W-1:0]   id_reg;
    logic              rsp_valid_reg;
    logic [WIDTH:0]    rsp_sum_reg;
    logic [ID_W-1:0]   rsp_id_reg;
    logic [7:0]        op_count_reg;

    logic [WIDTH-1:0]  a_slice [N_REQ];
    logic [WIDTH-1:0]  b_slice [N_REQ];
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   rr_ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign a_slice[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_slice[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from rr_ptr upward, wrapping at N_REQ; the first pending requester wins.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_sel;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        idx_sel     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_sel = ID_W'(idx);
            if (!grant_found && req_valid[idx_sel]) begin
                grant_found = 1'b1;
                grant_id    = idx_sel;
            end
        end
    end

    assign rr_ptr_next = (rsp_id_reg == ID_W'(N_REQ - 1)) ? '0 : rsp_id_reg + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_found) state_next = CALC;
            CALC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // rst gates req_ready so nothing is accepted while reset is held.
    always_comb begin
        req_ready = '0;
        busy      = (state_reg != IDLE);
        if (state_reg == IDLE && grant_found && !rst) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg    <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            id_reg        <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_sum_reg   <= '0;
            rsp_id_reg    <= '0;
            op_count_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        a_reg  <= a_slice[grant_id];
                        b_reg  <= b_slice[grant_id];
                        id_reg <= grant_id;
                    end
                end
                CALC: begin
                    rsp_sum_reg   <= {1'b0, a_reg} + {1'b0, b_reg};
                    rsp_id_reg    <= id_reg;
                    rsp_valid_reg <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        op_count_reg  <= op_count_reg + 8'd1;
                        rr_ptr_reg    <= rr_ptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_id    = rsp_id_reg;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter (N_REQ=4, WIDTH=4).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_adder_share_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_sum;
    logic [1:0]  rsp_id;
    logic [7:0]  op_count;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    adder_share_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .op_count  (op_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        step();
        step();
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL reset_req_ready actual=%b required=0000", req_ready);
        end
        n_cmp++;
        if ({rsp_valid, busy, rsp_sum, rsp_id, op_count} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_outputs actual valid=%b busy=%b sum=%h id=%0d cnt=%0d required all zero",
                     rsp_valid, busy, rsp_sum, rsp_id, op_count);
        end
        req_valid = 4'b0000;
        rst       = 1'b0;
        step();
        n_cmp++;
        if (req_ready !== 4'b0000 || busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_no_request actual ready=%b busy=%b required 0000/0", req_ready, busy);
        end
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        req_a     = 16'h0007;
        req_b     = 16'h0005;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL single_grant actual=%b required=0001", req_ready);
        end
        step();
        req_valid = 4'b0000;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        n_cmp++;
        if (req_ready !== 4'b0000 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_calc actual ready=%b busy=%b valid=%b required 0000/1/0",
                              req_ready, busy, rsp_valid);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 5'h0C || rsp_id !== 2'd0) begin
            n_bad++; $display("FAIL single_rsp actual valid=%b sum=%h id=%0d required 1/0c/0",
                              rsp_valid, rsp_sum, rsp_id);
        end
        $display("txn single id=%0d sum=%h", rsp_id, rsp_sum);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || op_count !== 8'd1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL single_done actual valid=%b cnt=%0d busy=%b required 0/1/0",
                              rsp_valid, op_count, busy);
        end
    endtask

    task automatic test_carry();
        logic [15:0] b_vec [2];
        logic [4:0]  exp_sum [2];
        b_vec[0] = 16'h0F00; exp_sum[0] = 5'h1E;
        b_vec[1] = 16'h0100; exp_sum[1] = 5'h10;
        for (int t = 0; t < 2; t++) begin
            req_valid = 4'b0100;
            req_a     = 16'h0F00;
            req_b     = b_vec[t];
            #1;
            n_cmp++;
            if (req_ready !== 4'b0100) begin
                n_bad++; $display("FAIL carry_grant[%0d] actual=%b required=0100", t, req_ready);
            end
            step();
            req_valid = 4'b0000;
            step();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_sum !== exp_sum[t] || rsp_id !== 2'd2) begin
                n_bad++; $display("FAIL carry_rsp[%0d] actual valid=%b sum=%h id=%0d required 1/%h/2",
                                  t, rsp_valid, rsp_sum, rsp_id, exp_sum[t]);
            end
            $display("txn carry id=%0d sum=%h", rsp_id, rsp_sum);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
        end
        n_cmp++;
        if (op_count !== 8'd3) begin
            n_bad++; $display("FAIL carry_count actual=%0d required=3", op_count);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [6];
        logic [4:0] sums [4];
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2;
        order[3] = 2'd3; order[4] = 2'd0; order[5] = 2'd1;
        sums[0] = 5'h07; sums[1] = 5'h11; sums[2] = 5'h1A; sums[3] = 5'h1E;
        pulse_reset();
        req_valid = 4'b1111;
        req_a     = 16'hFC93;
        req_b     = 16'hFE84;
        rsp_ready = 1'b1;
        #1;
        for (int t = 0; t < 6; t++) begin
            n_cmp++;
            if (req_ready !== (4'b0001 << order[t])) begin
                n_bad++; $display("FAIL rr_grant[%0d] actual=%b required=%b", t, req_ready, 4'b0001 << order[t]);
            end
            step();
            n_cmp++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
                n_bad++; $display("FAIL rr_calc[%0d] actual ready=%b valid=%b required 0000/0", t, req_ready, rsp_valid);
            end
            step();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_id !== order[t] || rsp_sum !== sums[order[t]]) begin
                n_bad++; $display("FAIL rr_rsp[%0d] actual valid=%b id=%0d sum=%h required 1/%0d/%h",
                                  t, rsp_valid, rsp_id, rsp_sum, order[t], sums[order[t]]);
            end
            $display("txn rr id=%0d sum=%h", rsp_id, rsp_sum);
            step();
        end
        n_cmp++;
        if (op_count !== 8'd6) begin
            n_bad++; $display("FAIL rr_count actual=%0d required=6", op_count);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL bp_grant actual=%b required=0100", req_ready);
        end
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 5'h1A || rsp_id !== 2'd2 || req_ready !== 4'b0000) begin
                n_bad++; $display("FAIL bp_hold[%0d] actual valid=%b sum=%h id=%0d ready=%b required 1/1a/2/0000",
                                  c, rsp_valid, rsp_sum, rsp_id, req_ready);
            end
            step();
        end
        $display("txn bp id=%0d sum=%h", rsp_id, rsp_sum);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'd7 || req_ready !== 4'b1000) begin
            n_bad++; $display("FAIL bp_release actual valid=%b busy=%b cnt=%0d ready=%b required 0/0/7/1000",
                              rsp_valid, busy, op_count, req_ready);
        end
    endtask

    task automatic test_counter_wrap();
        pulse_reset();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int t = 0; t < 257; t++) begin
            n_cmp++;
            if (req_ready !== (4'b0001 << (t % 4))) begin
                n_bad++; $display("FAIL wrap_grant[%0d] actual=%b required=%b", t, req_ready, 4'b0001 << (t % 4));
            end
            step();
            step();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(t % 4)) begin
                n_bad++; $display("FAIL wrap_rsp[%0d] actual valid=%b id=%0d required 1/%0d", t, rsp_valid, rsp_id, t % 4);
            end
            $display("txn wrap n=%0d id=%0d", t, rsp_id);
            step();
        end
        n_cmp++;
        if (op_count !== 8'd1) begin
            n_bad++; $display("FAIL wrap_count actual=%0d required=1", op_count);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        // In-flight in RESP, then async reset between edges
        req_valid = 4'b1111;
        step();
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
            n_bad++; $display("FAIL mid_pre actual valid=%b id=%0d required 1/1", rsp_valid, rsp_id);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'd0 || req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL mid_resp_rst actual valid=%b busy=%b cnt=%0d ready=%b required 0/0/0/0000",
                              rsp_valid, busy, op_count, req_ready);
        end
        #2 rst = 1'b0;
        req_valid = 4'b1001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL mid_first_grant actual=%b required=0001", req_ready);
        end
        step();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL mid_calc_busy actual=%b required=1", busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'd0) begin
            n_bad++; $display("FAIL mid_calc_rst actual valid=%b busy=%b cnt=%0d required 0/0/0",
                              rsp_valid, busy, op_count);
        end
        #2 rst = 1'b0;
        req_valid = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL mid_discard[%0d] actual valid=%b busy=%b required 0/0", c, rsp_valid, busy);
            end
        end
        $display("txn midop discarded");
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_counter_wrap();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
